// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states
//   REQ0/REQ1   : requester index constants (also the rr pointer encoding)
//   onehot()    : requester index -> one-hot grant vector
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] onehot(input logic id);
    return (id == REQ1) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and a UART transmitter.
//   reqN_valid/data/last : requester offers a byte (last = final byte of frame)
//   reqN_ready           : arbiter accepts the byte this cycle
//   tx_wr/tx_data        : write strobe and byte to the transmitter
//   tx_busy              : transmitter is serializing
//   grant/timeout        : current owner (one-hot) and forced-release pulse
// slave = arbiter side, master = requesters + transmitter side.
interface uart_tx_arbiter_if;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, tx_busy,
    output req0_ready, req1_ready, tx_wr, tx_data, grant, timeout
  );
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, tx_busy,
    input  req0_ready, req1_ready, tx_wr, tx_data, grant, timeout
  );
endinterface

// File: rtl/arb_timeout.sv
// Saturating idle counter for the frame lock.
//   clk, rst (async, active low)
//   clear    : zero the count (has priority)
//   count_en : count this cycle
//   expired  : count has reached TIMEOUT_CYC
module arb_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          cnt <= '0;
    else if (clear)                    cnt <= '0;
    else if (count_en && cnt != LIMIT) cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LIMIT);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter, with per-frame locking.
//   clk, rst (async, active low)
//   bus : uart_tx_arbiter_if.slave (requests, tx write/busy, grant, timeout)
// A byte with last=0 locks the transmitter to its requester until that
// requester sends a last=1 byte or stays silent for TIMEOUT_CYC idle cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);
  arb_state_e state_q, state_d;

  logic       armed_q;    // blocks accepts until one edge after reset release
  logic       rr_q;       // preferred requester when unlocked
  logic       lock_q;
  logic       lock_id_q;
  logic       cur_q;      // owner of the byte in flight
  logic       last_q;
  logic [7:0] data_q;
  logic [1:0] grant_q;

  logic [1:0] valid;
  logic       owner_vld, sel_vld, sel_id;
  logic       count_en, expired, to_fire;

  assign valid     = {bus.req1_valid, bus.req0_valid};
  assign owner_vld = valid[lock_id_q];
  assign count_en  = (state_q == IDLE) && lock_q && !owner_vld;
  assign to_fire   = count_en && expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel_vld = 1'b0;
    sel_id  = rr_q;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          if (lock_q) begin
            sel_vld = owner_vld;
            sel_id  = lock_id_q;
          end else if (valid[rr_q]) begin
            sel_vld = 1'b1;
            sel_id  = rr_q;
          end else if (valid[~rr_q]) begin
            sel_vld = 1'b1;
            sel_id  = ~rr_q;
          end
        end
        if (sel_vld) state_d = ISSUE;
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q   <= 1'b0;
      rr_q      <= REQ0;
      lock_q    <= 1'b0;
      lock_id_q <= REQ0;
      cur_q     <= REQ0;
      last_q    <= 1'b0;
      data_q    <= '0;
      grant_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      if (sel_vld) begin
        cur_q   <= sel_id;
        last_q  <= (sel_id == REQ1) ? bus.req1_last : bus.req0_last;
        data_q  <= (sel_id == REQ1) ? bus.req1_data : bus.req0_data;
        grant_q <= onehot(sel_id);
      end
      if (state_q == WAIT_DONE && !bus.tx_busy) begin
        if (last_q) begin
          lock_q  <= 1'b0;
          grant_q <= '0;
          rr_q    <= ~cur_q;
        end else begin
          lock_q    <= 1'b1;
          lock_id_q <= cur_q;
        end
      end
      // Silent lock owner: hand the preference to the other requester.
      if (to_fire) begin
        lock_q  <= 1'b0;
        grant_q <= '0;
        rr_q    <= ~lock_id_q;
      end
    end
  end

  arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (sel_vld || !lock_q),
    .count_en (count_en),
    .expired  (expired)
  );

  assign bus.req0_ready = sel_vld && (sel_id == REQ0);
  assign bus.req1_ready = sel_vld && (sel_id == REQ1);
  assign bus.tx_wr      = (state_q == ISSUE);
  assign bus.tx_data    = data_q;
  assign bus.grant      = grant_q;
  assign bus.timeout    = to_fire;
endmodule
